// File: rtl/msrh_cmt_queue.sv
`default_nettype none
// ============================================================================
//  Module      : msrh_cmt_queue
//  Description : In-order commit queue. Each entry tracks one dispatch group
//                (slot valid mask, slot done mask, exception flag). Done
//                reports from several ports are OR-merged into their target
//                entries, and the head entry commits once every valid slot
//                is done. An excepting commit flushes every younger entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrh_cmt_queue #(
    parameter  int CMT_ENTRY_SIZE = 16,
    parameter  int DISP_SIZE      = 4,
    parameter  int DONE_PORTS     = 4,
    localparam int CMT_ID_W       = $clog2(CMT_ENTRY_SIZE) + 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,

    // dispatch side
    input  logic                             i_disp_valid,
    input  logic [DISP_SIZE-1:0]             i_disp_inst_valid,
    output logic                             o_disp_ready,
    output logic [CMT_ID_W-1:0]              o_new_cmt_id,

    // done-report side
    input  logic [DONE_PORTS-1:0]            i_done_valid,
    input  logic [DONE_PORTS*CMT_ID_W-1:0]   i_done_cmt_id,
    input  logic [DONE_PORTS*DISP_SIZE-1:0]  i_done_grp_id,
    input  logic [DONE_PORTS-1:0]            i_done_except,

    // commit side
    output logic                             o_commit_valid,
    output logic [CMT_ID_W-1:0]              o_commit_cmt_id,
    output logic [DISP_SIZE-1:0]             o_commit_grp_mask,
    output logic                             o_commit_except,
    output logic                             o_flush,
    output logic [CMT_ID_W-1:0]              o_count
);

    localparam int                  c_IDX_W = CMT_ID_W - 1;
    localparam logic [CMT_ID_W-1:0] c_ONE   = CMT_ID_W'(1);

    // ------------------------------------------------------------------
    // Queue state
    // ------------------------------------------------------------------
    logic [CMT_ID_W-1:0]                       r_head;
    logic [CMT_ID_W-1:0]                       r_tail;
    logic [CMT_ENTRY_SIZE-1:0]                 r_valid;
    logic [CMT_ENTRY_SIZE-1:0]                 r_except;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0]  r_mask;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0]  r_done;

    // registered commit outputs
    logic                                      r_commit_valid;
    logic [CMT_ID_W-1:0]                       r_commit_cmt_id;
    logic [DISP_SIZE-1:0]                      r_commit_grp_mask;
    logic                                      r_commit_except;
    logic                                      r_flush;

    // ------------------------------------------------------------------
    // Pointer-derived status
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]   w_head_idx;
    logic [c_IDX_W-1:0]   w_tail_idx;
    logic [CMT_ID_W-1:0]  w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_head_complete;
    logic                 w_flush_pending;
    logic                 w_disp_ready;
    logic                 w_alloc;

    assign w_head_idx = r_head[c_IDX_W-1:0];
    assign w_tail_idx = r_tail[c_IDX_W-1:0];

    // Modulo arithmetic over the wrap bit gives occupancy directly.
    assign w_count = r_tail - r_head;
    assign w_empty = (r_head == r_tail);
    assign w_full  = (w_head_idx == w_tail_idx) &&
                     (r_head[CMT_ID_W-1] != r_tail[CMT_ID_W-1]);

    // The head commits this cycle whenever it is occupied and every valid
    // slot has reported done.
    assign w_head_complete = !w_empty && r_valid[w_head_idx] &&
                             ((r_done[w_head_idx] & r_mask[w_head_idx]) == r_mask[w_head_idx]);

    // An excepting head blocks dispatch for the cycle in which it commits,
    // so nothing is allocated into the space that is about to be flushed.
    assign w_flush_pending = w_head_complete && r_except[w_head_idx];

    // Ready looks at current state only; a slot freed by this cycle's
    // commit becomes usable next cycle.
    assign w_disp_ready = !w_full && !w_flush_pending;
    assign w_alloc      = i_disp_valid && w_disp_ready && (|i_disp_inst_valid);

    // ------------------------------------------------------------------
    // Per-port done qualification
    // ------------------------------------------------------------------
    logic [CMT_ID_W-1:0]   w_port_id  [DONE_PORTS];
    logic [CMT_ID_W-1:0]   w_port_off [DONE_PORTS];
    logic [c_IDX_W-1:0]    w_port_idx [DONE_PORTS];
    logic [DISP_SIZE-1:0]  w_port_hit [DONE_PORTS];
    logic [DONE_PORTS-1:0] w_port_ok;

    for (genvar p = 0; p < DONE_PORTS; p++) begin : g_port
        assign w_port_id[p]  = i_done_cmt_id[p*CMT_ID_W +: CMT_ID_W];
        assign w_port_idx[p] = w_port_id[p][c_IDX_W-1:0];
        // Distance from head; an ID is occupied when it lies in [head, tail).
        assign w_port_off[p] = w_port_id[p] - r_head;
        // Only slots that exist in the target group may be marked done.
        assign w_port_hit[p] = i_done_grp_id[p*DISP_SIZE +: DISP_SIZE] & r_mask[w_port_idx[p]];
        // Reports are dropped on the flush edge since every target dies.
        assign w_port_ok[p]  = i_done_valid[p] && (w_port_off[p] < w_count) &&
                               (|w_port_hit[p]) && !w_flush_pending;
    end

    // ------------------------------------------------------------------
    // Merge all accepted reports into per-entry set masks
    // ------------------------------------------------------------------
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0] w_done_set;
    logic [CMT_ENTRY_SIZE-1:0]                w_exc_set;

    // OR together every port that hits each entry so simultaneous reports
    // to the same group never lose a slot or an exception.
    always_comb begin
        w_done_set = '0;
        w_exc_set  = '0;
        for (int e = 0; e < CMT_ENTRY_SIZE; e++) begin
            for (int p = 0; p < DONE_PORTS; p++) begin
                if (w_port_ok[p] && (w_port_idx[p] == c_IDX_W'(e))) begin
                    w_done_set[e] = w_done_set[e] | w_port_hit[p];
                    w_exc_set[e]  = w_exc_set[e]  | i_done_except[p];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    // Pointer, entry and commit-output registers; later assignments in the
    // block take priority (flush over commit, allocate over done merge).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head            <= '0;
            r_tail            <= '0;
            r_valid           <= '0;
            r_except          <= '0;
            r_mask            <= '0;
            r_done            <= '0;
            r_commit_valid    <= 1'b0;
            r_commit_cmt_id   <= '0;
            r_commit_grp_mask <= '0;
            r_commit_except   <= 1'b0;
            r_flush           <= 1'b0;
        end else begin
            r_commit_valid <= w_head_complete;
            r_flush        <= w_flush_pending;

            if (w_head_complete) begin
                r_commit_cmt_id   <= r_head;
                r_commit_grp_mask <= r_mask[w_head_idx];
                r_commit_except   <= r_except[w_head_idx];
            end

            for (int e = 0; e < CMT_ENTRY_SIZE; e++) begin
                r_done[e]   <= r_done[e] | w_done_set[e];
                r_except[e] <= r_except[e] | w_exc_set[e];
            end

            if (w_head_complete) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + c_ONE;
            end

            if (w_flush_pending) begin
                // Everything younger than the excepting head is discarded.
                r_valid <= '0;
                r_tail  <= r_head + c_ONE;
            end else if (w_alloc) begin
                r_valid[w_tail_idx]  <= 1'b1;
                r_mask[w_tail_idx]   <= i_disp_inst_valid;
                r_done[w_tail_idx]   <= '0;
                r_except[w_tail_idx] <= 1'b0;
                r_tail               <= r_tail + c_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_disp_ready      = w_disp_ready;
    assign o_new_cmt_id      = r_tail;
    assign o_commit_valid    = r_commit_valid;
    assign o_commit_cmt_id   = r_commit_cmt_id;
    assign o_commit_grp_mask = r_commit_grp_mask;
    assign o_commit_except   = r_commit_except;
    assign o_flush           = r_flush;
    assign o_count           = w_count;

endmodule
`default_nettype wire
